// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encodings and op-classification helpers.
// The backtick macros double as the shared header contents (include-guarded);
// the package mirrors them as typed localparams.
// Optional feature macro: MULTDIV_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
`ifndef MULTDIV_V
`define MULTDIV_V
`define WIDTH_MDOP 4
`define MD_OP_NONE  4'd0
`define MD_OP_MULT  4'd1
`define MD_OP_MULTU 4'd2
`define MD_OP_DIV   4'd3
`define MD_OP_DIVU  4'd4
`define MD_OP_MTHI  4'd5
`define MD_OP_MTLO  4'd6
`define MD_OP_MADD  4'd7
`define MD_OP_MADDU 4'd8
`define MD_OP_MSUB  4'd9
`define MD_OP_MSUBU 4'd10
`define MDSEQ_IDLE  1'b0
`define MDSEQ_RUN   1'b1
`endif

package multdiv_sequencer_pkg;

    localparam int MDOP_W = `WIDTH_MDOP;
    typedef logic [MDOP_W-1:0] mdop_t;

    localparam mdop_t MD_OP_NONE  = `MD_OP_NONE;
    localparam mdop_t MD_OP_MULT  = `MD_OP_MULT;
    localparam mdop_t MD_OP_MULTU = `MD_OP_MULTU;
    localparam mdop_t MD_OP_DIV   = `MD_OP_DIV;
    localparam mdop_t MD_OP_DIVU  = `MD_OP_DIVU;
    localparam mdop_t MD_OP_MTHI  = `MD_OP_MTHI;
    localparam mdop_t MD_OP_MTLO  = `MD_OP_MTLO;
    localparam mdop_t MD_OP_MADD  = `MD_OP_MADD;
    localparam mdop_t MD_OP_MADDU = `MD_OP_MADDU;
    localparam mdop_t MD_OP_MSUB  = `MD_OP_MSUB;
    localparam mdop_t MD_OP_MSUBU = `MD_OP_MSUBU;

    localparam logic [0:0] MDSEQ_IDLE = `MDSEQ_IDLE;
    localparam logic [0:0] MDSEQ_RUN  = `MDSEQ_RUN;

    // Multiply-class ops (MULT latency). MADD family only exists when enabled.
    function automatic logic md_is_mul(input mdop_t op);
        logic r;
        r = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
`ifdef MULTDIV_MADD_EN
        r = r || (op == MD_OP_MADD) || (op == MD_OP_MADDU) ||
                 (op == MD_OP_MSUB) || (op == MD_OP_MSUBU);
`endif
        return r;
    endfunction

    // Divide-class ops (DIV latency).
    function automatic logic md_is_div(input mdop_t op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    // Ops that occupy the unit for more than zero cycles.
    function automatic logic md_is_long(input mdop_t op);
        return md_is_mul(op) || md_is_div(op);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer interface.
// Handshake: the EX stage presents start/op/src_a/src_b/dis for one cycle;
// the unit takes it (accept) only when start & !dis & idle & long op, or
// applies MTHI/MTLO at once. md_busy = busy | accept tells pipeline control
// to stall; a start presented while busy is simply dropped.
interface multdiv_sequencer_if;
    import multdiv_sequencer_pkg::*;

    logic        start;
    mdop_t       op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        dis;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_busy;
    logic [0:0]  dbg_state;

    modport master (
        output start, op, src_a, src_b, dis,
        input  hi, lo, busy, md_busy, dbg_state
    );

    modport slave (
        input  start, op, src_a, src_b, dis,
        output hi, lo, busy, md_busy, dbg_state
    );
endinterface

// File: rtl/multdiv_sequencer_md_calc.sv
// md_calc: combinational HI/LO result for one multiply/divide op.
// Divide by zero leaves HI/LO as given; 0x80000000 / -1 naturally yields
// lo=0x80000000, hi=0 through the magnitude-based signed divide.
// Optional feature macro: MULTDIV_MADD_EN (accumulating multiplies).
module md_calc
    import multdiv_sequencer_pkg::*;
(
    input  mdop_t       op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] abs_b_nz;
    logic [31:0] b_nz;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        b_zero;

    assign prod_s = $signed({{32{src_a_i[31]}}, src_a_i}) * $signed({{32{src_b_i[31]}}, src_b_i});
    assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

    // Divisor forced to 1 when zero so the dividers never see x; result is discarded then.
    assign b_zero   = (src_b_i == 32'd0);
    assign abs_a    = src_a_i[31] ? (32'd0 - src_a_i) : src_a_i;
    assign abs_b    = src_b_i[31] ? (32'd0 - src_b_i) : src_b_i;
    assign abs_b_nz = b_zero ? 32'd1 : abs_b;
    assign b_nz     = b_zero ? 32'd1 : src_b_i;

    assign q_mag = abs_a / abs_b_nz;
    assign r_mag = abs_a % abs_b_nz;
    assign q_s   = (src_a_i[31] ^ src_b_i[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = src_a_i[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = src_a_i / b_nz;
    assign r_u   = src_a_i % b_nz;

    // Result select; unlisted ops and divide-by-zero hand back HI/LO unchanged.
    always_comb begin
        res_hi_o = hi_i;
        res_lo_o = lo_i;
        case (op_i)
            MD_OP_MULT:  {res_hi_o, res_lo_o} = prod_s;
            MD_OP_MULTU: {res_hi_o, res_lo_o} = prod_u;
            MD_OP_DIV: begin
                if (!b_zero) begin
                    res_lo_o = q_s;
                    res_hi_o = r_s;
                end
            end
            MD_OP_DIVU: begin
                if (!b_zero) begin
                    res_lo_o = q_u;
                    res_hi_o = r_u;
                end
            end
`ifdef MULTDIV_MADD_EN
            MD_OP_MADD:  {res_hi_o, res_lo_o} = {hi_i, lo_i} + prod_s;
            MD_OP_MADDU: {res_hi_o, res_lo_o} = {hi_i, lo_i} + prod_u;
            MD_OP_MSUB:  {res_hi_o, res_lo_o} = {hi_i, lo_i} - prod_s;
            MD_OP_MSUBU: {res_hi_o, res_lo_o} = {hi_i, lo_i} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: owns HI/LO, sequences multi-cycle multiply/divide ops
// with a down-counter FSM (IDLE/RUN) and drives MDBusy for pipeline control.
// The result is computed at accept and held in pending registers; HI/LO cannot
// change while RUN, so this equals computing at commit (including MADD family).
// Optional feature macro: MULTDIV_MADD_EN (handled in the package and md_calc).
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    multdiv_sequencer_if.slave     md
);

    localparam int CNT_W = 16;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             take;
    logic             accept;

    md_calc u_md_calc (
        .op_i     (md.op),
        .src_a_i  (md.src_a),
        .src_b_i  (md.src_b),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo)
    );

    assign take   = md.start && !md.dis && (state_q == MDSEQ_IDLE);
    assign accept = take && md_is_long(md.op);

    // Next-state: accept/MTHI/MTLO from IDLE, countdown and commit in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (state_q == MDSEQ_IDLE) begin
            if (accept) begin
                state_d   = MDSEQ_RUN;
                cnt_d     = md_is_div(md.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
            end else if (take && (md.op == MD_OP_MTHI)) begin
                hi_d = md.src_a;
            end else if (take && (md.op == MD_OP_MTLO)) begin
                lo_d = md.src_a;
            end
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = MDSEQ_IDLE;
                cnt_d   = '0;
                hi_d    = pend_hi_q;
                lo_d    = pend_lo_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDSEQ_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.busy      = (state_q == MDSEQ_RUN);
    assign md.md_busy   = (state_q == MDSEQ_RUN) || accept;
    assign md.dbg_state = state_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed testbench for multdiv_sequencer with hand-computed expectations.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_multdiv_sequencer;
    import multdiv_sequencer_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    multdiv_sequencer_if md ();

    multdiv_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input mdop_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic d);
        md.start = st;
        md.op    = op;
        md.src_a = a;
        md.src_b = b;
        md.dis   = d;
    endtask

    // Long op from IDLE: md_busy in cycle t, busy for n cycles, result at t+n+1.
    task automatic run_long(input string tag, input mdop_t op, input logic [31:0] a,
                            input logic [31:0] b, input int n,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1 drive(1'b1, op, a, b, 1'b0);
        @(negedge clk);
        chk({tag, "_mdbusy_t"}, md.md_busy, 1);
        chk({tag, "_busy_t"}, md.busy, 0);
        @(posedge clk); #1 drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk({tag, "_busy_run"}, {md.busy, md.md_busy, md.dbg_state}, 3'b111);
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, "_busy_done"}, md.busy, 0);
        chk({tag, "_hi"}, md.hi, exp_hi);
        chk({tag, "_lo"}, md.lo, exp_lo);
    endtask

    // Zero-latency move to HI/LO.
    task automatic mt(input mdop_t op, input logic [31:0] v);
        @(posedge clk); #1 drive(1'b1, op, v, 32'd0, 1'b0);
        @(negedge clk);
        chk("mt_mdbusy", md.md_busy, 0);
        @(posedge clk); #1 drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("mt_busy", md.busy, 0);
    endtask

    // A start that must have no effect.
    task automatic no_effect(input string tag, input mdop_t op, input logic [31:0] a,
                             input logic [31:0] b, input logic d,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1 drive(1'b1, op, a, b, d);
        @(negedge clk);
        chk({tag, "_mdbusy"}, md.md_busy, 0);
        @(posedge clk); #1 drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk({tag, "_busy"}, md.busy, 0);
        chk({tag, "_hi"}, md.hi, exp_hi);
        chk({tag, "_lo"}, md.lo, exp_lo);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy2"}, md.busy, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", md.hi, 0);
        chk("rst_lo", md.lo, 0);
        chk("rst_busy", {md.busy, md.md_busy, md.dbg_state}, 3'b000);
        @(posedge clk); #1 reset = 1'b0;

        run_long("mult", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_long("divu", MD_OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_long("div_neg", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        mt(MD_OP_MTHI, 32'h11);
        mt(MD_OP_MTLO, 32'h22);
        chk("mt_hi", md.hi, 32'h11);
        chk("mt_lo", md.lo, 32'h22);
        run_long("div0", MD_OP_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_long("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        no_effect("multu_dis", MD_OP_MULTU, 32'd3, 32'd3, 1'b1, 32'd0, 32'h8000_0000);
        no_effect("mthi_dis", MD_OP_MTHI, 32'h1234, 32'd0, 1'b1, 32'd0, 32'h8000_0000);

        mt(MD_OP_MTHI, 32'hABCD);
        chk("mthi_hi", md.hi, 32'hABCD);

        no_effect("op_none", MD_OP_NONE, 32'd7, 32'd7, 1'b0, 32'hABCD, 32'h8000_0000);
        no_effect("op_bad", 4'hF, 32'd7, 32'd7, 1'b0, 32'hABCD, 32'h8000_0000);

        // Second start during RUN is dropped; the first op commits on time.
        @(posedge clk); #1 drive(1'b1, MD_OP_MULT, 32'd3, 32'd4, 1'b0);   // t
        @(posedge clk); #1 drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);   // t+1
        @(posedge clk); #1 drive(1'b1, MD_OP_MTHI, 32'h7777, 32'd0, 1'b0); // t+2
        @(negedge clk);
        chk("run2_mdbusy", {md.md_busy, md.dbg_state}, 2'b11);
        @(posedge clk); #1 drive(1'b1, MD_OP_DIV, 32'd9, 32'd3, 1'b0);   // t+3
        @(posedge clk); #1 drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);   // t+4
        chk("run2_hi_mid", md.hi, 32'hABCD);
        @(posedge clk);                                                    // t+5
        @(negedge clk);
        chk("run2_busy5", md.busy, 1);
        @(posedge clk);                                                    // t+6
        @(negedge clk);
        chk("run2_busy6", md.busy, 0);
        chk("run2_hi", md.hi, 32'd0);
        chk("run2_lo", md.lo, 32'd12);

        // Reset in the middle of an operation discards it.
        @(posedge clk); #1 drive(1'b1, MD_OP_MULT, 32'd5, 32'd5, 1'b0);   // t
        @(posedge clk); #1 drive(1'b0, MD_OP_NONE, 32'd0, 32'd0, 1'b0);   // t+1
        @(posedge clk);                                                    // t+2
        @(posedge clk); #1 reset = 1'b1;                                   // t+3
        @(posedge clk); #1 reset = 1'b0;                                   // t+4
        @(negedge clk);
        chk("rmid_busy", {md.busy, md.md_busy, md.dbg_state}, 3'b000);
        chk("rmid_hi", md.hi, 0);
        chk("rmid_lo", md.lo, 0);
        @(posedge clk);                                                    // t+5
        @(posedge clk);                                                    // t+6
        @(negedge clk);
        chk("rmid_hi6", md.hi, 0);
        chk("rmid_lo6", md.lo, 0);
        @(posedge clk);                                                    // t+7
        @(negedge clk);
        chk("rmid_lo7", md.lo, 0);
        chk("rmid_busy7", md.busy, 0);

        // Accumulating multiply: {0,FFFFFFFF} + 1*1 wraps into HI.
        mt(MD_OP_MTHI, 32'd0);
        mt(MD_OP_MTLO, 32'hFFFF_FFFF);
`ifdef MULTDIV_MADD_EN
        run_long("maddu", MD_OP_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        no_effect("maddu", MD_OP_MADDU, 32'd1, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
